// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per
// stage, registered carry between stages, skewed operands and de-skewed sums.
module cla_adder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / GROUP;
  // Skew storage is needed for stages 1..N-1 only; keep one entry when N=1.
  localparam int unsigned NS = (N > 1) ? N - 1 : 1;

  // Reject configurations where the width does not split into whole groups.
  if (GROUP == 0 || (WIDTH % GROUP) != 0) begin : g_cfg_check
    $error("cla_adder_pipe: WIDTH must be a non-zero multiple of GROUP");
  end

  // Flat lookahead carries for one group: returns {c_(G-1) .. c_0, cin_group}.
  // Every carry is a sum of products of g/p and cin; no carry feeds another.
  function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] g,
                                               input logic [GROUP-1:0] p,
                                               input logic             ci);
    logic [GROUP:0] c;
    logic [GROUP:0] gc;
    logic           t;
    gc = {g, ci};
    c  = '0;
    c[0] = ci;
    for (int j = 0; j < int'(GROUP); j++) begin
      for (int m = 0; m <= j + 1; m++) begin
        t = gc[m];
        for (int q = m; q <= j; q++) begin
          t = t & p[q];
        end
        c[j+1] = c[j+1] | t;
      end
    end
    return c;
  endfunction

  logic [N-1:0]     v_q;
  logic [N-1:0]     cy_q;
  logic [WIDTH-1:0] res_q    [N];
  logic [WIDTH-1:0] skew_a_q [NS];
  logic [WIDTH-1:0] skew_b_q [NS];
  logic [NS-1:0]    mode_q;
  logic             ovf_q;
  logic             en;

  logic [GROUP-1:0] st_a [N];
  logic [GROUP-1:0] st_b [N];
  logic [GROUP-1:0] st_s [N];
  logic [GROUP:0]   st_c [N];
  logic [N-1:0]     st_ci;

  // Whole pipe advances together unless a held result is blocking the output.
  assign en        = !v_q[N-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[N-1];
  assign sum       = res_q[N-1];
  assign cout      = cy_q[N-1];
  assign ovf       = ovf_q;

  // Per-stage group operands, carry-in and lookahead sum.
  always_comb begin
    st_a  = '{default: '0};
    st_b  = '{default: '0};
    st_s  = '{default: '0};
    st_c  = '{default: '0};
    st_ci = '0;
    st_a[0]  = a[GROUP-1:0];
    st_b[0]  = sub ? ~b[GROUP-1:0] : b[GROUP-1:0];
    st_ci[0] = sub | cin;
    for (int k = 1; k < int'(N); k++) begin
      st_a[k]  = skew_a_q[k-1][GROUP-1:0];
      st_b[k]  = mode_q[k-1] ? ~skew_b_q[k-1][GROUP-1:0] : skew_b_q[k-1][GROUP-1:0];
      st_ci[k] = cy_q[k-1];
    end
    for (int k = 0; k < int'(N); k++) begin
      st_c[k] = lookahead(st_a[k] & st_b[k], st_a[k] ^ st_b[k], st_ci[k]);
      st_s[k] = (st_a[k] ^ st_b[k]) ^ st_c[k][GROUP-1:0];
    end
  end

  // Stage registers: valid, carry, de-skewed result, skewed operands and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      cy_q   <= '0;
      mode_q <= '0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        res_q[k] <= '0;
      end
      for (int k = 0; k < int'(NS); k++) begin
        skew_a_q[k] <= '0;
        skew_b_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0]   <= in_valid;
      res_q[0] <= WIDTH'(st_s[0]);
      for (int k = 1; k < int'(N); k++) begin
        v_q[k]   <= v_q[k-1];
        res_q[k] <= res_q[k-1] | (WIDTH'(st_s[k]) << (k * int'(GROUP)));
      end
      for (int k = 0; k < int'(N); k++) begin
        cy_q[k] <= st_c[k][GROUP];
      end
      if (N > 1) begin
        skew_a_q[0] <= a >> GROUP;
        skew_b_q[0] <= b >> GROUP;
        mode_q[0]   <= sub;
      end
      for (int k = 1; k < int'(NS); k++) begin
        skew_a_q[k] <= skew_a_q[k-1] >> GROUP;
        skew_b_q[k] <= skew_b_q[k-1] >> GROUP;
        mode_q[k]   <= mode_q[k-1];
      end
      ovf_q <= st_c[N-1][GROUP] ^ st_c[N-1][GROUP-1];
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed corner cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_cla_adder_pipe;

  localparam int unsigned W = 32;
  localparam int unsigned G = 4;
  localparam int unsigned N = W / G;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_vec;
  int   n_miss;
  exp_t q[$];
  exp_t nxt;

  cla_adder_pipe #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain wide arithmetic; overflow from operand/result sign bits.
  function automatic exp_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb);
    exp_t         r;
    logic [W:0]   full;
    logic [W-1:0] ye;
    logic         c;
    ye   = sb ? ~y : y;
    c    = sb ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, ye} + (W+1)'(c);
    r.s  = full[W-1:0];
    r.co = full[W];
    r.ov = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
    return r;
  endfunction

  // One clock: score output/input transfers at the negedge, return 1 after posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("out_expected", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sum", 64'(sum), 64'(e.s));
        check("cout", 64'(cout), 64'(e.co));
        check("ovf", 64'(ovf), 64'(e.ov));
      end
    end
    if (in_valid && in_ready) q.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb);
    a = x; b = y; cin = ci; sub = sb;
  endtask

  task automatic drive_rand();
    set_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    nxt = ref_op(a, b, cin, sub);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
    check("drain_empty", 64'(q.size()), 64'(0));
    cycle();
    cycle();
  endtask

  // Single item into an empty pipe; count edges until it is presented.
  task automatic lat_test(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb, input exp_t e);
    int edges;
    set_op(x, y, ci, sb);
    nxt = e;
    in_valid = 1'b1;
    cycle();
    edges = 1;
    in_valid = 1'b0;
    while (!out_valid && edges < 50) begin
      cycle();
      edges++;
    end
    check("latency", 64'(edges), 64'(N));
    drain();
  endtask

  task automatic dir_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb, input exp_t e);
    set_op(x, y, ci, sb);
    nxt = e;
    in_valid = 1'b1;
    cycle();
  endtask

  initial begin
    exp_t         e;
    logic [W-1:0] snap_s;
    logic         snap_c;
    logic         snap_o;
    int           sent;
    int           cyc;

    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_op('0, '0, 1'b0, 1'b0);
    nxt = ref_op('0, '0, 1'b0, 1'b0);

    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Full carry chain across all groups, with latency
    e = '{s: 32'h0000_0000, co: 1'b1, ov: 1'b0};
    lat_test(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e);

    // Directed add/sub corner cases, back to back
    e = '{s: 32'h8000_0000, co: 1'b0, ov: 1'b1};
    dir_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e);
    e = '{s: 32'h2345_678A, co: 1'b0, ov: 1'b0};
    dir_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, e);
    e = '{s: 32'hFFFF_FFFE, co: 1'b0, ov: 1'b0};
    dir_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, e);
    e = '{s: 32'h7FFF_FFFF, co: 1'b1, ov: 1'b1};
    dir_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, e);
    drain();

    // 20 random items, bubble every 5th cycle
    sent = 0;
    cyc = 0;
    while (sent < 20) begin
      in_valid = (cyc % 5) != 4;
      drive_rand();
      if (in_valid) sent++;
      cycle();
      cyc++;
    end
    drain();

    // Fill the pipe, then stall the consumer for 6 cycles
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand();
      cycle();
    end
    out_ready = 1'b0;
    #1;
    check("stall_out_valid", 64'(out_valid), 64'(1));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    snap_s = sum;
    snap_c = cout;
    snap_o = ovf;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      cycle();
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_sum", 64'(sum), 64'(snap_s));
      check("hold_cout", 64'(cout), 64'(snap_c));
      check("hold_ovf", 64'(ovf), 64'(snap_o));
    end
    out_ready = 1'b1;
    drain();

    // Random valid and random consumer backpressure
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      drive_rand();
      cycle();
    end
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with 3 items in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_sum", 64'(sum), 64'(0));
    check("arst_cout", 64'(cout), 64'(0));
    check("arst_ovf", 64'(ovf), 64'(0));
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_rand();
    lat_test(a, b, cin, sub, nxt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
